cory_unpack_n: RTL and testbench

Generic 1-to-R unpacker. Accepts one wide beat of R lanes × N bits and delivers each lane on its own valid/ready output channel; lanes drain independently. Successor to the fixed-ratio unpackers: any R from 2 to 64, a per-beat lane mask, and a selectable in-order delivery mode. Sits between a wide producer (bus or FIFO) and R narrow consumers in the datapath.

---
 rtl/cory_unpack_n.sv | 63 ++++++
 tb/tb_cory_unpack_n.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cory_unpack_n.sv
// cory_unpack_n: generic 1-to-R unpacker, one wide beat drained as R independent lane channels.
// Revision 1.0
`default_nettype none

module cory_unpack_n #(
  parameter int N       = 8,
  parameter int R       = 4,
  parameter int ORDERED = 0,
  parameter int A       = N * R
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_a_v,
  input  logic [A-1:0] i_a_d,
  input  logic [R-1:0] i_a_m,
  output logic         o_a_r,
  output logic [R-1:0] o_zx_v,
  output logic [A-1:0] o_zx_d,
  input  logic [R-1:0] i_zx_r,
  output logic [R-1:0] o_pend
);

  logic [A-1:0] d_q;
  logic [R-1:0] p_q;
  logic [R-1:0] lane_v;
  logic [R-1:0] fire;
  logic [R-1:0] p_n;
  logic         accept;

  generate
    if (ORDERED != 0) begin : g_ordered
      // Isolate the lowest pending lane: x & -x.
      assign lane_v = p_q & (~p_q + {{(R-1){1'b0}}, 1'b1});
    end else begin : g_parallel
      assign lane_v = p_q;
    end
  endgenerate

  // Ready looks through this cycle's lane fires so the next beat enters without a bubble.
  assign fire   = lane_v & i_zx_r;
  assign p_n    = p_q & ~fire;
  assign o_a_r  = (p_n == '0);
  assign accept = i_a_v & o_a_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q <= '0;
      d_q <= '0;
    end else if (accept) begin
      p_q <= i_a_m;
      d_q <= i_a_d;
    end else begin
      p_q <= p_n;
    end
  end

  assign o_zx_v = lane_v;
  assign o_zx_d = d_q;
  assign o_pend = p_q;

endmodule

`default_nettype wire

// File: tb/tb_cory_unpack_n.sv
// tb_cory_unpack_n: directed checks of cory_unpack_n, parallel (u0) and in-order (u1) instances.
// Revision 1.0
`default_nettype none

module tb_cory_unpack_n;

  localparam int N = 8;
  localparam int R = 4;
  localparam int A = N * R;

  logic         clk;
  logic         reset;

  logic         a_v0, a_r0;
  logic [A-1:0] a_d0, zd0;
  logic [R-1:0] a_m0, zv0, zr0, pend0;

  logic         a_v1, a_r1;
  logic [A-1:0] a_d1, zd1;
  logic [R-1:0] a_m1, zv1, zr1, pend1;

  int n_checks;
  int n_fail;

  cory_unpack_n #(.N(N), .R(R), .ORDERED(0)) u0 (
    .clk    (clk),
    .reset  (reset),
    .i_a_v  (a_v0),
    .i_a_d  (a_d0),
    .i_a_m  (a_m0),
    .o_a_r  (a_r0),
    .o_zx_v (zv0),
    .o_zx_d (zd0),
    .i_zx_r (zr0),
    .o_pend (pend0)
  );

  cory_unpack_n #(.N(N), .R(R), .ORDERED(1)) u1 (
    .clk    (clk),
    .reset  (reset),
    .i_a_v  (a_v1),
    .i_a_d  (a_d1),
    .i_a_m  (a_m1),
    .o_a_r  (a_r1),
    .o_zx_v (zv1),
    .o_zx_d (zd1),
    .i_zx_r (zr1),
    .o_pend (pend1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed and outputs checked mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] lane(input logic [A-1:0] d, input int k);
    return d[k*N +: N];
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    a_v0 = 1'b0; a_d0 = '0; a_m0 = '0; zr0 = '0;
    a_v1 = 1'b0; a_d1 = '0; a_m1 = '0; zr1 = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state and idle
    #1;
    check("rst_zd0", zd0, 0);
    check("rst_pend1", pend1, 0);
    check("rst_ar1", a_r1, 1);
    for (int i = 0; i < 5; i++) begin
      check("idle_ar", a_r0, 1);
      check("idle_zv", zv0, 0);
      check("idle_pend", pend0, 0);
      tick();
    end

    // Three back-to-back full beats, all ready
    a_v0 = 1'b1; a_d0 = 32'h44332211; a_m0 = 4'hF; zr0 = 4'hF;
    tick();
    a_d0 = 32'h88776655;
    #1;
    check("b2b1_zv", zv0, 4'hF);
    check("b2b1_l2", lane(zd0, 2), 8'h33);
    check("b2b1_ar", a_r0, 1);
    tick();
    a_d0 = 32'hCCBBAA99;
    #1;
    check("b2b2_zv", zv0, 4'hF);
    check("b2b2_l2", lane(zd0, 2), 8'h77);
    check("b2b2_ar", a_r0, 1);
    tick();
    a_v0 = 1'b0;
    #1;
    check("b2b3_zv", zv0, 4'hF);
    check("b2b3_l2", lane(zd0, 2), 8'hBB);
    tick();
    check("b2b_drain_zv", zv0, 0);

    // Backpressure on lane 2 only
    a_v0 = 1'b1; a_d0 = 32'h44332211; a_m0 = 4'hF; zr0 = 4'b1011;
    tick();
    a_d0 = 32'h55667788;
    #1;
    check("bp_c1_zv", zv0, 4'hF);
    check("bp_c1_ar", a_r0, 0);
    tick();
    check("bp_c2_pend", pend0, 4'b0100);
    check("bp_c2_zv", zv0, 4'b0100);
    check("bp_c2_ar", a_r0, 0);
    tick();
    check("bp_c3_pend", pend0, 4'b0100);
    check("bp_c3_ar", a_r0, 0);
    zr0 = 4'hF;
    #1;
    check("bp_rel_ar", a_r0, 1);
    check("bp_rel_l2", lane(zd0, 2), 8'h33);
    tick();
    a_v0 = 1'b0;
    #1;
    check("bp_next_pend", pend0, 4'hF);
    check("bp_next_l0", lane(zd0, 0), 8'h88);
    tick();
    check("bp_drain_pend", pend0, 0);

    // Zero-mask beat then single-lane beat
    a_v0 = 1'b1; a_d0 = 32'hDEADBEEF; a_m0 = 4'h0;
    tick();
    a_d0 = 32'h000000AB; a_m0 = 4'h1;
    #1;
    check("zm_zv", zv0, 0);
    check("zm_ar", a_r0, 1);
    tick();
    a_v0 = 1'b0;
    #1;
    check("m1_zv", zv0, 4'h1);
    check("m1_l0", lane(zd0, 0), 8'hAB);
    tick();
    check("m1_drain_zv", zv0, 0);

    // Reset during a partially held beat
    a_v0 = 1'b1; a_d0 = 32'h11223344; a_m0 = 4'b0110; zr0 = 4'h0;
    tick();
    a_v0 = 1'b0;
    #1;
    check("rmid_pend", pend0, 4'b0110);
    check("rmid_ar", a_r0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rmid_zv", zv0, 0);
    check("rmid_pend0", pend0, 0);
    check("rmid_ar1", a_r0, 1);
    check("rmid_zd", zd0, 0);
    zr0 = 4'hF;
    tick();
    check("rmid_stale", zv0, 0);

    // In-order delivery, sparse mask
    a_v1 = 1'b1; a_d1 = 32'hA1B2C3D4; a_m1 = 4'b1010; zr1 = 4'hF;
    tick();
    a_v1 = 1'b0;
    #1;
    check("ord_c1_zv", zv1, 4'b0010);
    check("ord_c1_ar", a_r1, 0);
    check("ord_c1_l1", lane(zd1, 1), 8'hC3);
    tick();
    check("ord_c2_zv", zv1, 4'b1000);
    check("ord_c2_ar", a_r1, 1);
    check("ord_c2_l3", lane(zd1, 3), 8'hA1);
    tick();
    check("ord_c3_zv", zv1, 0);

    // In-order delivery holds the offered lane under backpressure
    a_v1 = 1'b1; a_d1 = 32'h0F0E0D0C; a_m1 = 4'b0101; zr1 = 4'b0100;
    tick();
    a_v1 = 1'b0;
    #1;
    check("ordbp_c1_zv", zv1, 4'b0001);
    check("ordbp_c1_ar", a_r1, 0);
    tick();
    check("ordbp_c2_zv", zv1, 4'b0001);
    check("ordbp_c2_pend", pend1, 4'b0101);
    zr1 = 4'hF;
    tick();
    check("ordbp_c3_zv", zv1, 4'b0100);
    check("ordbp_c3_l2", lane(zd1, 2), 8'h0E);
    tick();
    check("ordbp_c4_pend", pend1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
